// File: rtl/cv32e41p_register_file_sb.sv
// cv32e41p_register_file_sb
// Parametrised integer register file with NUM_READ read ports, NUM_WRITE
// write ports (higher index wins on address collision) and a per-register
// pending-writeback scoreboard used by the ID stage for hazard detection.
// Optional macro CV32E41P_RF_BYPASS_EN: same-cycle write-to-read forwarding.
//
// Allocation handshake: alloc_req_i is held by the requester until
// alloc_gnt_o is seen high in the same cycle; the reservation takes effect
// at that clock edge. A refused request carries no state: nothing is queued.
module cv32e41p_register_file_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_READ   = 3,
  parameter int NUM_WRITE  = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_READ-1:0][ADDR_WIDTH-1:0]  raddr_i,
  output logic [NUM_READ-1:0][DATA_WIDTH-1:0]  rdata_o,
  output logic [NUM_READ-1:0]                  rbusy_o,
  input  logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0] waddr_i,
  input  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_WRITE-1:0]                 we_i,
  input  logic                                 alloc_req_i,
  input  logic [ADDR_WIDTH-1:0]                alloc_addr_i,
  output logic                                 alloc_gnt_o,
  input  logic                                 flush_i,
  output logic [(2**ADDR_WIDTH)-1:0]           busy_o,
  output logic [ADDR_WIDTH:0]                  pending_cnt_o
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;
  logic                  alloc_wr_hit;

  // Grant when the target is free or is being written back this very cycle.
  always_comb begin
    alloc_wr_hit = 1'b0;
    for (int w = 0; w < NUM_WRITE; w++) begin
      if (we_i[w] && (waddr_i[w] == alloc_addr_i)) alloc_wr_hit = 1'b1;
    end
    alloc_gnt_o = alloc_req_i && !flush_i && (!busy_q[alloc_addr_i] || alloc_wr_hit);
  end

  // Next state: writes in ascending port order so the highest index wins;
  // writeback clears come before the allocation set so a set wins.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int w = 0; w < NUM_WRITE; w++) begin
      if (we_i[w]) begin
        busy_d[waddr_i[w]] = 1'b0;
        if (!((ZERO_REG == 1) && (waddr_i[w] == '0))) mem_d[waddr_i[w]] = wdata_i[w];
      end
    end
    if (alloc_gnt_o) busy_d[alloc_addr_i] = 1'b1;
    if (flush_i) busy_d = '0;
    if (ZERO_REG == 1) busy_d[0] = 1'b0;
  end

  // Storage and scoreboard flops; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '{default: '0};
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  // Read ports: flop contents, optionally overridden by a same-cycle write.
  always_comb begin
    for (int k = 0; k < NUM_READ; k++) begin
      rdata_o[k] = mem_q[raddr_i[k]];
      rbusy_o[k] = busy_q[raddr_i[k]];
`ifdef CV32E41P_RF_BYPASS_EN
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (we_i[w] && (waddr_i[w] == raddr_i[k]) &&
            !((ZERO_REG == 1) && (raddr_i[k] == '0))) begin
          rdata_o[k] = wdata_i[w];
          rbusy_o[k] = 1'b0;
        end
      end
`endif
      if ((ZERO_REG == 1) && (raddr_i[k] == '0)) rdata_o[k] = '0;
    end
  end

  // Population count of outstanding reservations.
  always_comb begin
    pending_cnt_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      pending_cnt_o = pending_cnt_o + {{ADDR_WIDTH{1'b0}}, busy_q[i]};
    end
  end

  assign busy_o = busy_q;

endmodule

// File: tb/tb_cv32e41p_register_file_sb.sv
// Testbench for cv32e41p_register_file_sb (default parameters).
module tb_cv32e41p_register_file_sb;

  logic              clk;
  logic              rst_n;
  logic [2:0][4:0]   raddr;
  logic [2:0][31:0]  rdata;
  logic [2:0]        rbusy;
  logic [1:0][4:0]   waddr;
  logic [1:0][31:0]  wdata;
  logic [1:0]        we;
  logic              alloc_req;
  logic [4:0]        alloc_addr;
  logic              alloc_gnt;
  logic              flush;
  logic [31:0]       busy;
  logic [5:0]        pending_cnt;

  int checks = 0;
  int failures = 0;

  cv32e41p_register_file_sb dut (
    .clk(clk), .rst_n(rst_n),
    .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
    .alloc_req_i(alloc_req), .alloc_addr_i(alloc_addr), .alloc_gnt_o(alloc_gnt),
    .flush_i(flush), .busy_o(busy), .pending_cnt_o(pending_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: register contents and reservation set
  logic [31:0] mem_m [32];
  logic        busy_m [32];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mem_m[i] = '0;
      busy_m[i] = 1'b0;
    end
  endtask

  function automatic logic exp_gnt();
    logic hit = 1'b0;
    for (int w = 0; w < 2; w++) if (we[w] && waddr[w] == alloc_addr) hit = 1'b1;
    return alloc_req && !flush && (!busy_m[alloc_addr] || hit);
  endfunction

  function automatic logic [31:0] exp_rdata(int k);
    logic [31:0] v = (raddr[k] == 0) ? 32'h0 : mem_m[raddr[k]];
`ifdef CV32E41P_RF_BYPASS_EN
    for (int w = 0; w < 2; w++) if (we[w] && waddr[w] == raddr[k] && raddr[k] != 0) v = wdata[w];
`endif
    return v;
  endfunction

  function automatic logic exp_rbusy(int k);
    logic b = busy_m[raddr[k]];
`ifdef CV32E41P_RF_BYPASS_EN
    for (int w = 0; w < 2; w++) if (we[w] && waddr[w] == raddr[k] && raddr[k] != 0) b = 1'b0;
`endif
    return b;
  endfunction

  function automatic logic [31:0] exp_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = busy_m[i];
    return v;
  endfunction

  function automatic logic [5:0] exp_cnt();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(busy_m[i]);
    return 6'(c);
  endfunction

  // apply the architectural rules for one clock edge
  task automatic model_update();
    logic g = exp_gnt();
    for (int w = 0; w < 2; w++) begin
      if (we[w]) begin
        busy_m[waddr[w]] = 1'b0;
        if (waddr[w] != 0) mem_m[waddr[w]] = wdata[w];
      end
    end
    if (g && alloc_addr != 0) busy_m[alloc_addr] = 1'b1;
    if (flush) for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
  endtask

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic set_idle();
    raddr = '0; waddr = '0; wdata = '0; we = '0;
    alloc_req = 1'b0; alloc_addr = '0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        req;
    logic [4:0]  aa;
    logic        fl;
    logic [4:0]  ra;
    logic        e_gnt;
    logic [31:0] e_rd;
    logic        e_rb;
    logic [31:0] e_busy;
    logic [5:0]  e_cnt;
  } vec_t;

  function automatic vec_t mk(logic [1:0] we_v, logic [4:0] wa0, logic [31:0] wd0,
                              logic [4:0] wa1, logic [31:0] wd1, logic req, logic [4:0] aa,
                              logic fl, logic [4:0] ra, logic e_gnt, logic [31:0] e_rd,
                              logic e_rb, logic [31:0] e_busy, logic [5:0] e_cnt);
    vec_t v;
    v.we = we_v; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.req = req; v.aa = aa; v.fl = fl; v.ra = ra;
    v.e_gnt = e_gnt; v.e_rd = e_rd; v.e_rb = e_rb; v.e_busy = e_busy; v.e_cnt = e_cnt;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    // directed vectors; read address never collides with a same-cycle write
    tbl.push_back(mk(2'b01, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0,  0, 32'h0, 0, 32'h0, 0));
    tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0,             0, 32'h0, 0, 32'h0, 0));
    tbl.push_back(mk(2'b11, 5, 32'h11111111, 5, 32'h22222222, 0, 0, 0, 1, 0, 32'h0, 0, 32'h0, 0));
    tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 5,             0, 32'h22222222, 0, 32'h0, 0));
    tbl.push_back(mk(2'b00, 0, 0, 0, 0, 1, 7, 0, 7,             1, 32'h0, 0, 32'h80, 1));
    tbl.push_back(mk(2'b00, 0, 0, 0, 0, 1, 7, 0, 7,             0, 32'h0, 1, 32'h80, 1));
    tbl.push_back(mk(2'b01, 7, 32'h77, 0, 0, 0, 0, 0, 5,        0, 32'h22222222, 0, 32'h0, 0));
    tbl.push_back(mk(2'b00, 0, 0, 0, 0, 1, 9, 0, 7,             1, 32'h77, 0, 32'h200, 1));
    tbl.push_back(mk(2'b10, 0, 0, 9, 32'h99, 1, 9, 0, 5,        1, 32'h22222222, 0, 32'h200, 1));
    tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 9,             0, 32'h99, 1, 32'h200, 1));
    tbl.push_back(mk(2'b00, 0, 0, 0, 0, 1, 3, 0, 0,             1, 32'h0, 0, 32'h208, 2));
    tbl.push_back(mk(2'b00, 0, 0, 0, 0, 1, 4, 0, 0,             1, 32'h0, 0, 32'h218, 3));
    tbl.push_back(mk(2'b00, 0, 0, 0, 0, 1, 6, 0, 0,             1, 32'h0, 0, 32'h258, 4));
    tbl.push_back(mk(2'b00, 0, 0, 0, 0, 1, 8, 1, 9,             0, 32'h99, 1, 32'h0, 0));
    tbl.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 9,             0, 32'h99, 0, 32'h0, 0));
    tbl.push_back(mk(2'b00, 0, 0, 0, 0, 1, 0, 0, 0,             1, 32'h0, 0, 32'h0, 0));

    // reset
    set_idle();
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", busy, 32'h0);
    check("reset_cnt", 32'(pending_cnt), 32'h0);
    for (int i = 0; i < 32; i++) begin
      raddr[0] = 5'(i);
      #1;
      check("reset_rdata", rdata[0], 32'h0);
      check("reset_rbusy", 32'(rbusy[0]), 32'h0);
    end
    @(negedge clk);

    // table-driven directed phase
    for (int n = 0; n < tbl.size(); n++) begin
      set_idle();
      we = tbl[n].we; waddr[0] = tbl[n].wa0; wdata[0] = tbl[n].wd0;
      waddr[1] = tbl[n].wa1; wdata[1] = tbl[n].wd1;
      alloc_req = tbl[n].req; alloc_addr = tbl[n].aa; flush = tbl[n].fl;
      raddr[0] = tbl[n].ra;
      #1;
      check($sformatf("vec%0d_gnt", n), 32'(alloc_gnt), 32'(tbl[n].e_gnt));
      check($sformatf("vec%0d_rdata", n), rdata[0], tbl[n].e_rd);
      check($sformatf("vec%0d_rbusy", n), 32'(rbusy[0]), 32'(tbl[n].e_rb));
      tick();
      check($sformatf("vec%0d_busy", n), busy, tbl[n].e_busy);
      check($sformatf("vec%0d_cnt", n), 32'(pending_cnt), 32'(tbl[n].e_cnt));
    end

    // same-cycle write-to-read on a reserved register
    set_idle();
    waddr[0] = 12; wdata[0] = 32'h00001234; we = 2'b01;
    tick();
    set_idle();
    alloc_req = 1'b1; alloc_addr = 12;
    tick();
    set_idle();
    waddr[0] = 12; wdata[0] = 32'hCAFEF00D; we = 2'b01; raddr[0] = 12;
    #1;
`ifdef CV32E41P_RF_BYPASS_EN
    check("bypass_rdata", rdata[0], 32'hCAFEF00D);
    check("bypass_rbusy", 32'(rbusy[0]), 32'h0);
`else
    check("nobypass_rdata", rdata[0], 32'h00001234);
    check("nobypass_rbusy", 32'(rbusy[0]), 32'h1);
`endif
    tick();
    set_idle();
    raddr[0] = 12;
    #1;
    check("wb_rdata", rdata[0], 32'hCAFEF00D);
    check("wb_rbusy", 32'(rbusy[0]), 32'h0);

    // asynchronous reset in the middle of operation
    @(negedge clk);
    set_idle();
    alloc_req = 1'b1; alloc_addr = 12;
    tick();
    set_idle();
    raddr[0] = 12;
    check("pre_rst_cnt", 32'(pending_cnt), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_busy", busy, 32'h0);
    check("async_rst_cnt", 32'(pending_cnt), 32'h0);
    check("async_rst_rdata", rdata[0], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // randomized phase against the model
    for (int n = 0; n < 400; n++) begin
      we = 2'($urandom_range(0, 3));
      for (int w = 0; w < 2; w++) begin
        waddr[w] = 5'($urandom_range(0, 15));
        wdata[w] = $urandom;
      end
      for (int k = 0; k < 3; k++) raddr[k] = 5'($urandom_range(0, 15));
      alloc_req = 1'($urandom_range(0, 1));
      alloc_addr = 5'($urandom_range(0, 15));
      flush = ($urandom_range(0, 15) == 0);
      #1;
      check("rnd_gnt", 32'(alloc_gnt), 32'(exp_gnt()));
      for (int k = 0; k < 3; k++) begin
        check($sformatf("rnd_rdata%0d", k), rdata[k], exp_rdata(k));
        check($sformatf("rnd_rbusy%0d", k), 32'(rbusy[k]), 32'(exp_rbusy(k)));
      end
      tick();
      check("rnd_busy", busy, exp_busy_vec());
      check("rnd_cnt", 32'(pending_cnt), 32'(exp_cnt()));
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
